alu_status_reg: RTL and testbench

- Processor status register (P) for the 6502 core.
- Sits downstream of the ALU and consumes its registered flag outputs (CO, Z, N, V) one cycle after the control unit issues an ALU operation.
- Also handles flag-modifying instructions (SEC/CLC/SED/CLD/SEI/CLI/CLV), BIT, PLP/RTI loads and the P image for PHP/BRK/IRQ pushes.
- Provides the delayed interrupt mask used by IRQ gating and the BCD mode bit fed back to the ALU.

---
 rtl/alu_status_reg.sv | 136 +++++++++++++
 tb/tb_alu_status_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_reg.sv
// 6502 processor status register (P): pipelined ALU flag capture, explicit flag ops,
// PLP/RTI loads, push image and the instruction-delayed IRQ mask.
module alu_status_reg #(
    parameter bit CMOS_CLR_D = 1'b0,
    parameter bit RESET_I    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RDY,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       upd_bit,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    input  logic       alu_co,
    input  logic [7:0] db_in,
    input  logic       load_p,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       clr_v,
    input  logic       irq_entry,
    input  logic       brk_push,
    input  logic       instr_done,
    output logic [7:0] p_out,
    output logic       C,
    output logic       Z,
    output logic       I,
    output logic       D,
    output logic       V,
    output logic       N,
    output logic       bcd,
    output logic       i_mask
);

    logic c_q, z_q, i_q, d_q, v_q, n_q, i_mask_q;
    logic c_d, z_d, i_d, d_d, v_d, n_d, i_mask_d;
    logic pend_nz_q, pend_c_q, pend_v_q, pend_z_q;

    // B and the unused bit are not stored in P; they only exist in the push image.
    logic unused_db;
    assign unused_db = ^db_in[5:4];

    // Assignments run lowest priority first so later ones win per flag.
    always_comb begin
        c_d      = c_q;
        z_d      = z_q;
        i_d      = i_q;
        d_d      = d_q;
        v_d      = v_q;
        n_d      = n_q;
        i_mask_d = i_mask_q;

        if (upd_bit) begin
            n_d = db_in[7];
            v_d = db_in[6];
        end

        if (set_c || clr_c) c_d = set_c;
        if (set_d || clr_d) d_d = set_d;
        if (set_i || clr_i) i_d = set_i;
        if (clr_v)          v_d = 1'b0;

        if (!load_p) begin
            if (pend_nz_q) begin
                n_d = alu_n;
                z_d = alu_z;
            end
            if (pend_z_q) z_d = alu_z;
            if (pend_c_q) c_d = alu_co;
            if (pend_v_q) v_d = alu_v;
        end else begin
            n_d = db_in[7];
            v_d = db_in[6];
            d_d = db_in[3];
            i_d = db_in[2];
            z_d = db_in[1];
            c_d = db_in[0];
        end

        if (irq_entry) begin
            i_d = 1'b1;
            if (CMOS_CLR_D) d_d = 1'b0;
        end

        if (irq_entry) begin
            i_mask_d = 1'b1;
        end else if (instr_done) begin
            i_mask_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            i_q       <= RESET_I;
            d_q       <= 1'b0;
            v_q       <= 1'b0;
            n_q       <= 1'b0;
            i_mask_q  <= RESET_I;
            pend_nz_q <= 1'b0;
            pend_c_q  <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_z_q  <= 1'b0;
        end else if (RDY) begin
            c_q       <= c_d;
            z_q       <= z_d;
            i_q       <= i_d;
            d_q       <= d_d;
            v_q       <= v_d;
            n_q       <= n_d;
            i_mask_q  <= i_mask_d;
            pend_nz_q <= upd_nz;
            pend_c_q  <= upd_c;
            pend_v_q  <= upd_v;
            pend_z_q  <= upd_bit;
        end
    end

    assign p_out  = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign C      = c_q;
    assign Z      = z_q;
    assign I      = i_q;
    assign D      = d_q;
    assign V      = v_q;
    assign N      = n_q;
    assign bcd    = d_q;
    assign i_mask = i_mask_q;

endmodule

// File: tb/tb_alu_status_reg.sv
// Bench for alu_status_reg: directed vector table, then random stimulus vs a queue-based model.
module tb_alu_status_reg;

    logic       clk = 1'b0;
    logic       reset, rdy;
    logic       upd_nz, upd_c, upd_v, upd_bit;
    logic       alu_n, alu_z, alu_v, alu_co;
    logic [7:0] db_in;
    logic       load_p, set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v;
    logic       irq_entry, brk_push, instr_done;
    logic [7:0] p_out;
    logic       f_c, f_z, f_i, f_d, f_v, f_n, bcd, i_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_status_reg dut (
        .clk        (clk),
        .reset      (reset),
        .RDY        (rdy),
        .upd_nz     (upd_nz),
        .upd_c      (upd_c),
        .upd_v      (upd_v),
        .upd_bit    (upd_bit),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_co     (alu_co),
        .db_in      (db_in),
        .load_p     (load_p),
        .set_c      (set_c),
        .clr_c      (clr_c),
        .set_d      (set_d),
        .clr_d      (clr_d),
        .set_i      (set_i),
        .clr_i      (clr_i),
        .clr_v      (clr_v),
        .irq_entry  (irq_entry),
        .brk_push   (brk_push),
        .instr_done (instr_done),
        .p_out      (p_out),
        .C          (f_c),
        .Z          (f_z),
        .I          (f_i),
        .D          (f_d),
        .V          (f_v),
        .N          (f_n),
        .bcd        (bcd),
        .i_mask     (i_mask)
    );

    // Control word bit positions
    localparam int UNZ = 0, UC = 1, UV = 2, UBIT = 3, LDP = 4, SC = 5, CC = 6, SD = 7;
    localparam int CD = 8, SI = 9, CI = 10, CV = 11, IRQ = 12, DONE = 13, NRDY = 14, RST = 15;

    typedef struct {
        string       name;
        logic [15:0] ctl;
        logic [3:0]  alu;    // {n, z, v, co}
        logic [7:0]  db;
        logic [7:0]  exp_p;  // expected P image with brk_push = 0
        logic        exp_mask;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [15:0] ctl, input logic [3:0] alu,
                       input logic [7:0] db, input logic [7:0] ep, input logic em);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.alu = alu; v.db = db; v.exp_p = ep; v.exp_mask = em;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [15:0] ctl, input logic [3:0] alu, input logic [7:0] db,
                         input logic brk);
        upd_nz = ctl[UNZ]; upd_c = ctl[UC]; upd_v = ctl[UV]; upd_bit = ctl[UBIT];
        load_p = ctl[LDP]; set_c = ctl[SC]; clr_c = ctl[CC]; set_d = ctl[SD];
        clr_d = ctl[CD]; set_i = ctl[SI]; clr_i = ctl[CI]; clr_v = ctl[CV];
        irq_entry = ctl[IRQ]; instr_done = ctl[DONE];
        rdy = ~ctl[NRDY]; reset = ~ctl[RST];
        {alu_n, alu_z, alu_v, alu_co} = alu;
        db_in = db; brk_push = brk;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic [7:0] ep, input logic em);
        check({nm, " p_out"}, p_out, ep);
        check({nm, " flags"}, {2'b0, f_n, f_v, f_d, f_i, f_z, f_c},
              {2'b0, ep[7], ep[6], ep[3], ep[2], ep[1], ep[0]});
        check({nm, " bcd"}, {7'b0, bcd}, {7'b0, ep[3]});
        check({nm, " i_mask"}, {7'b0, i_mask}, {7'b0, em});
    endtask

    // Reference model: flags plus a queue of issued-but-unapplied ALU captures.
    typedef struct packed { logic nz, c, v, z; } op_t;
    op_t  pq[$];
    logic mn, mv, md, mi, mz, mc, mmask;

    task automatic model_step(input logic [15:0] ctl, input logic [3:0] alu, input logic [7:0] db);
        op_t due;
        bit  has_due;
        if (ctl[RST]) begin
            {mn, mv, md, mz, mc} = '0;
            mi = 1'b1; mmask = 1'b1;
            pq.delete();
            return;
        end
        if (ctl[NRDY]) return;
        has_due = pq.size() > 0;
        if (has_due) due = pq.pop_front();
        if (|ctl[3:0]) pq.push_back({ctl[UNZ], ctl[UC], ctl[UV], ctl[UBIT]});
        if (ctl[UBIT]) begin mn = db[7]; mv = db[6]; end
        if (ctl[SC] | ctl[CC]) mc = ctl[SC];
        if (ctl[SD] | ctl[CD]) md = ctl[SD];
        if (ctl[SI] | ctl[CI]) mi = ctl[SI];
        if (ctl[CV]) mv = 1'b0;
        if (has_due && !ctl[LDP]) begin
            if (due.nz) begin mn = alu[3]; mz = alu[2]; end
            if (due.z) mz = alu[2];
            if (due.c) mc = alu[0];
            if (due.v) mv = alu[1];
        end
        if (ctl[LDP]) {mn, mv, md, mi, mz, mc} = {db[7:6], db[3:0]};
        if (ctl[IRQ]) mi = 1'b1;
        if (ctl[IRQ]) mmask = 1'b1;
        else if (ctl[DONE]) mmask = mi;
    endtask

    function automatic logic pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    initial begin
        logic [15:0] ctl;
        logic [3:0]  alu;
        logic [7:0]  db;
        logic        brk;

        add("reset",       16'(1 << RST),                  4'h0, 8'h00, 8'h24, 1'b1);
        add("idle",        16'h0,                          4'h0, 8'h00, 8'h24, 1'b1);
        add("issue nz c",  16'((1 << UNZ) | (1 << UC)),    4'h0, 8'h00, 8'h24, 1'b1);
        add("apply nz c",  16'h0,                          4'b1001, 8'h00, 8'hA5, 1'b1);
        add("issue 2",     16'((1 << UNZ) | (1 << UC)),    4'h0, 8'h00, 8'hA5, 1'b1);
        add("stall",       16'(1 << NRDY),                 4'b1001, 8'h00, 8'hA5, 1'b1);
        add("late apply",  16'h0,                          4'b0100, 8'h00, 8'h26, 1'b1);
        add("issue c",     16'(1 << UC),                   4'h0, 8'h00, 8'h26, 1'b1);
        add("load_p ff",   16'(1 << LDP),                  4'h0, 8'hFF, 8'hEF, 1'b1);
        add("dropped c",   16'h0,                          4'h0, 8'h00, 8'hEF, 1'b1);
        add("clr_i",       16'(1 << CI),                   4'h0, 8'h00, 8'hEB, 1'b1);
        add("mask hold 1", 16'h0,                          4'h0, 8'h00, 8'hEB, 1'b1);
        add("mask hold 2", 16'h0,                          4'h0, 8'h00, 8'hEB, 1'b1);
        add("instr_done",  16'(1 << DONE),                 4'h0, 8'h00, 8'hEB, 1'b0);
        add("irq_entry",   16'(1 << IRQ),                  4'h0, 8'h00, 8'hEF, 1'b1);
        add("load_p 00",   16'(1 << LDP),                  4'h0, 8'h00, 8'h20, 1'b1);
        add("bit issue",   16'(1 << UBIT),                 4'h0, 8'hC0, 8'hE0, 1'b1);
        add("bit z",       16'h0,                          4'b0100, 8'h00, 8'hE2, 1'b1);
        add("set+clr c",   16'((1 << SC) | (1 << CC)),     4'h0, 8'h00, 8'hE3, 1'b1);
        add("set d i",     16'((1 << SD) | (1 << CD) | (1 << SI)), 4'h0, 8'h00, 8'hEF, 1'b1);
        add("clr v d c",   16'((1 << CV) | (1 << CD) | (1 << CC)), 4'h0, 8'h00, 8'hA6, 1'b1);
        add("issue v",     16'(1 << UV),                   4'h0, 8'h00, 8'hA6, 1'b1);
        add("b2b v",       16'(1 << UV),                   4'b0010, 8'h00, 8'hE6, 1'b1);
        add("b2b v 2",     16'h0,                          4'h0, 8'h00, 8'hA6, 1'b1);
        add("irq vs load", 16'((1 << IRQ) | (1 << LDP) | (1 << CI) | (1 << DONE)),
            4'h0, 8'h00, 8'h24, 1'b1);
        add("issue c 2",   16'(1 << UC),                   4'h0, 8'h00, 8'h24, 1'b1);
        add("alu vs set",  16'(1 << SC),                   4'h0, 8'h00, 8'h24, 1'b1);
        add("cli at done", 16'((1 << CI) | (1 << DONE)),   4'h0, 8'h00, 8'h20, 1'b0);
        add("reset no rdy", 16'((1 << RST) | (1 << NRDY)), 4'h0, 8'h00, 8'h24, 1'b1);

        foreach (tbl[k]) begin
            brk = k[0];
            drive(tbl[k].ctl, tbl[k].alu, tbl[k].db, brk);
            @(posedge clk);
            @(negedge clk);
            check_all(tbl[k].name, tbl[k].exp_p | {3'b0, brk, 4'b0}, tbl[k].exp_mask);
        end

        ctl = 16'(1 << RST);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) begin
                ctl = '0;
                ctl[UNZ] = pct(30); ctl[UC] = pct(30); ctl[UV] = pct(30); ctl[UBIT] = pct(20);
                ctl[LDP] = pct(5);
                for (int b = SC; b <= CV; b++) ctl[b] = pct(15);
                ctl[IRQ] = pct(5); ctl[DONE] = pct(25); ctl[NRDY] = pct(15); ctl[RST] = pct(2);
            end
            alu = 4'($urandom_range(15));
            db  = 8'($urandom_range(255));
            brk = 1'($urandom_range(1));
            drive(ctl, alu, db, brk);
            @(posedge clk);
            model_step(ctl, alu, db);
            @(negedge clk);
            check_all("random", {mn, mv, 1'b1, brk, md, mi, mz, mc}, mmask);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
